// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests,
// buffers one returned instruction for IF/ID and handles stall and redirect flushes.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] FLUSH_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] instruction_o,
  output logic        valid_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] r_pc_out;
  logic [XLEN-1:0] r_instr;
  logic            r_valid;

  logic            w_free;
  logic            w_req;
  logic            w_hs;
  logic [XLEN-1:0] w_redirect_pc;

  // Buffer can take a new instruction when empty or being consumed this cycle.
  assign w_free        = !r_valid || !stall_i;
  assign w_req         = rst_i && (r_state == S_REQ) && w_free && !redirect_i;
  assign w_hs          = w_req && imem_ready_i;
  assign w_redirect_pc = redirect_pc_i & ~XLEN'(32'h3);

  assign imem_req_o    = w_req;
  assign imem_addr_o   = r_pc;
  assign pc_o          = r_pc_out;
  assign instruction_o = r_instr;
  assign valid_o       = r_valid;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      r_pc_out <= '0;
      r_instr  <= FLUSH_INSTR;
      r_valid  <= 1'b0;
    end else if (redirect_i) begin
      // Redirect flushes the buffer even under stall; an in-flight fetch gets drained.
      r_pc     <= w_redirect_pc;
      r_pc_out <= '0;
      r_instr  <= FLUSH_INSTR;
      r_valid  <= 1'b0;
      case (r_state)
        S_REQ:   r_state <= S_REQ;
        S_WAIT:  r_state <= imem_rvalid_i ? S_REQ : S_DRAIN;
        S_DRAIN: r_state <= imem_rvalid_i ? S_REQ : S_DRAIN;
        default: r_state <= S_REQ;
      endcase
    end else begin
      if (r_valid && !stall_i) begin
        r_valid  <= 1'b0;
        r_pc_out <= '0;
        r_instr  <= FLUSH_INSTR;
      end
      case (r_state)
        S_REQ: begin
          if (w_hs) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + XLEN'(4);
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            r_valid  <= 1'b1;
            r_pc_out <= r_req_pc;
            r_instr  <= imem_rdata_i;
            r_state  <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid_i) r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule
